// File: rtl/controller_if.sv
// Control bus between the multicycle controller and its datapath.
// Instruction/flag inputs plus every mux select and write enable.
interface controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [2:0]  ALUControl;

    modport master (
        output Instr, ALUFlags,
        input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc,
        input  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );

    modport slave (
        input  Instr, ALUFlags,
        output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc,
        output RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );
endinterface

// File: rtl/controller.sv
// Multicycle ARM-subset Moore controller with optional conditional execution.
// Define CONDEX_EN to add NZCV flag registers and condition evaluation.
module controller (
    input  logic     clk,
    input  logic     reset,
    controller_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB,
        MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
    } state_t;

    state_t state, next;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond_ok;
    logic [2:0] alu_dp;
    logic       is_addsub;

    assign cond  = bus.Instr[19:16];
    assign op    = bus.Instr[15:14];
    assign funct = bus.Instr[13:8];
    assign rd    = bus.Instr[3:0];

    always_comb begin
        case (funct[4:1])
            4'b0100: alu_dp = 3'b000;
            4'b0010: alu_dp = 3'b001;
            4'b0000: alu_dp = 3'b010;
            4'b1100: alu_dp = 3'b011;
            default: alu_dp = 3'b000;
        endcase
    end

    assign is_addsub = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010);

`ifdef CONDEX_EN
    logic [3:0] flags;
    logic       n, z, c, v;
    logic       cond_eval;

    assign {n, z, c, v} = flags;

    always_comb begin
        case (cond)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = ~z;
            4'b0010: cond_eval = c;
            4'b0011: cond_eval = ~c;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = ~n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = ~v;
            4'b1000: cond_eval = c & ~z;
            4'b1001: cond_eval = ~c | z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = ~z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    end

    // Only ADD/SUB produce meaningful carry and overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if ((state == EXECUTER || state == EXECUTEI)
                     && funct[0] && cond_ok) begin
            flags[3:2] <= bus.ALUFlags[3:2];
            if (is_addsub)
                flags[1:0] <= bus.ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cond_ok <= 1'b0;
        else if (state == DECODE)
            cond_ok <= cond_eval;
    end
`else
    logic unused_cond;

    assign cond_ok     = 1'b1;
    assign unused_cond = ^{cond, bus.ALUFlags, is_addsub};
`endif

    logic unused_rn;
    assign unused_rn = ^bus.Instr[7:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= next;
    end

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:  next = DECODE;
            DECODE: begin
                case (op)
                    2'b00:   next = funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   next = MEMADR;
                    2'b10:   next = BRANCH;
                    default: next = FETCH;
                endcase
            end
            MEMADR:   next = funct[0] ? MEMRD : MEMWR;
            MEMRD:    next = MEMWB;
            EXECUTER: next = ALUWB;
            EXECUTEI: next = ALUWB;
            default:  next = FETCH;
        endcase
    end

    logic pc_w, reg_w, mem_w, ir_w;

    always_comb begin
        pc_w           = 1'b0;
        reg_w          = 1'b0;
        mem_w          = 1'b0;
        ir_w           = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ALUControl = 3'b000;
        case (state)
            FETCH: begin
                ir_w          = 1'b1;
                pc_w          = 1'b1;
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            DECODE: begin
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            MEMADR:   bus.ALUSrcB = 2'b01;
            MEMRD:    bus.AdrSrc  = 1'b1;
            MEMWR: begin
                bus.AdrSrc = 1'b1;
                mem_w      = cond_ok;
            end
            EXECUTER: bus.ALUControl = alu_dp;
            EXECUTEI: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = alu_dp;
            end
            ALUWB: begin
                reg_w = cond_ok;
                pc_w  = cond_ok & (rd == 4'hF);
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                reg_w         = cond_ok;
                pc_w          = cond_ok & (rd == 4'hF);
            end
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                pc_w          = cond_ok;
            end
            default: ;
        endcase
    end

    // Write enables are squashed for as long as reset is held
    assign bus.PCWrite  = pc_w  & ~reset;
    assign bus.RegWrite = reg_w & ~reset;
    assign bus.MemWrite = mem_w & ~reset;
    assign bus.IRWrite  = ir_w  & ~reset;
    assign bus.RegSrc   = {op == 2'b01, op == 2'b10};
    assign bus.ImmSrc   = op;
endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high; clears state immediately.
REQ-003 SHALL have: Instr  input  20  instruction bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
REQ-004 SHALL have: ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle.
REQ-005 SHALL have write-enable outputs: PCWrite, RegWrite, MemWrite, IRWrite, each output 1.
REQ-006 SHALL have: AdrSrc  output  1  address select (0 PC, 1 ALUOut).
REQ-007 SHALL have: RegSrc  output  2  [0]=(Op==10), [1]=(Op==01), combinational from Instr.
REQ-008 SHALL have: ALUSrcA  output  2 (00 A, 01 PC); ALUSrcB  output  2 (00 WriteData, 01 ExtImm, 10 constant 4).
REQ-009 SHALL have: ResultSrc  output  2 (00 ALUOut, 01 Data, 10 ALUResult); ImmSrc  output  2 equal to Op.
REQ-010 SHALL have: ALUControl  output  3 (000 ADD, 001 SUB, 010 AND, 011 ORR).

Function
REQ-011 SHALL implement Moore FSM states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-012 SHALL transition: FETCH->DECODE; DECODE->MEMADR if Op=01, EXECUTER if Op=00 and Funct[5]=0, EXECUTEI if Op=00 and Funct[5]=1, BRANCH if Op=10, FETCH if Op=11 (no side effects).
REQ-013 SHALL transition: MEMADR->MEMRD if Funct[0]=1 else MEMWR; MEMRD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-014 SHALL drive in FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=000.
REQ-015 SHALL drive in DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=000, all write enables 0.
REQ-016 SHALL drive in EXECUTER: ALUSrcA=00, ALUSrcB=00; EXECUTEI: ALUSrcA=00, ALUSrcB=01; both ALUControl from Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, other 000.
REQ-017 SHALL drive in MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=000.
REQ-018 SHALL drive in MEMRD: AdrSrc=1, ResultSrc=00; MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=cond_ok.
REQ-019 SHALL drive in ALUWB: ResultSrc=00, RegWrite=cond_ok; MEMWB: ResultSrc=01, RegWrite=cond_ok; in both, PCWrite=cond_ok when Rd=1111.
REQ-020 SHALL drive in BRANCH: ALUSrcA=00, ALUSrcB=01, ALUControl=000, ResultSrc=10, PCWrite=cond_ok.
REQ-021 SHALL drive unlisted mux outputs 00 and unlisted write enables 0 in every state.
REQ-022 SHALL latch cond_ok at the DECODE->next rising edge from Cond evaluated against the flag registers (EQ..LE per ARM, 1110 AL true, 1111 false).
REQ-023 SHALL update flags at the rising edge leaving EXECUTER/EXECUTEI when Funct[0]=1 and cond_ok: N,Z always; C,V only for ADD/SUB.
REQ-024 SHALL yield instruction latency: B 3 cycles, data-processing 4, STR 4, LDR 5, Op=11 2.

Reset
REQ-025 SHALL on reset assertion, asynchronously: state=FETCH, flags NZCV=0000, cond_ok=0.
REQ-026 SHALL force PCWrite, RegWrite, MemWrite, IRWrite to 0 while reset is high; mux outputs take FETCH values.
REQ-027 SHALL perform the first fetch on the first rising edge after reset deasserts; reset mid-instruction abandons it with no further writes.

Configuration
REQ-028 SHALL, when CONDEX_EN is defined, implement the flag registers and condition evaluation of REQ-022/023.
REQ-029 SHALL, when CONDEX_EN is undefined, omit flag registers, tie cond_ok=1, and execute every instruction unconditionally.

Verification
REQ-030 SHALL cover: reset held 2 cycles then released, Instr=E2802005 (ADD imm) -> states FETCH,DECODE,EXECUTEI,ALUWB; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
REQ-031 SHALL cover: Instr=E5912000 (LDR) -> MEMADR,MEMRD,MEMWB; AdrSrc=1 in MEMRD; ResultSrc=01, RegWrite=1 in MEMWB; 5 cycles total.
REQ-032 SHALL cover: Instr=E0520003 (SUBS), ALUFlags=0100 in EXECUTER, then Instr=0A000002 (BEQ) -> PCWrite=1 in BRANCH; same with ALUFlags=0000 -> PCWrite=0 in BRANCH (CONDEX_EN defined).
REQ-033 SHALL cover: Instr=E5812000 (STR) -> MEMWR with MemWrite=1, RegWrite=0 throughout; Instr=EC000000 (Op=11) -> DECODE->FETCH, no writes.
REQ-034 SHALL cover: reset asserted during MEMRD -> state FETCH and all enables 0 within the same cycle, without waiting for a clock edge.
